// File: rtl/currctrl_gpio_master.sv
// -----------------------------------------------------------------------------
// currctrl_gpio_master
//
// Avalon-MM initiator for the CurrCTRL GPIO PIO slave. Provides a local
// valid/ready command port for single PIO register reads/writes, and runs an
// autonomous edge-capture poller: every POLL_PERIOD cycles it reads register 3
// and, if any bit is set, writes the same value back to clear it and reports
// the captured bits as a one-cycle event.
//
// Parameters:
//   POLL_PERIOD  poll interval in clk cycles (>= 8)
//   READ_WAIT    extra cycles address/chipselect are held before readdata is
//                sampled (the PIO needs 1)
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (cmd_ready combinational)
//   cmd_write/cmd_address/cmd_wdata  command fields
//   rsp_valid/rsp_rdata           command completion pulse and read data
//   poll_enable                   enables the poll timer
//   event_valid/event_bits        edge-capture event pulse and captured bits
//   m_address/m_chipselect/m_write_n/m_writedata/m_readdata  PIO bus
// -----------------------------------------------------------------------------
module currctrl_gpio_master #(
   parameter int POLL_PERIOD = 1000,
   parameter int READ_WAIT   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [2:0]  cmd_address,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   input  logic        poll_enable,
   output logic        event_valid,
   output logic [31:0] event_bits,
   output logic [2:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [31:0] m_writedata,
   input  logic [31:0] m_readdata
);

   localparam int CNT_W  = $clog2(POLL_PERIOD);
   localparam int WAIT_W = $clog2(READ_WAIT + 2);
   localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(POLL_PERIOD - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(READ_WAIT);
   localparam logic [2:0]        EDGE_ADDR  = 3'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD_WR,
      ST_CMD_RD,
      ST_CMD_RSP,
      ST_POLL_RD,
      ST_POLL_CLR
   } state_t;

   state_t            state_reg, state_next;
   logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
   logic [CNT_W-1:0]  poll_cnt_reg, poll_cnt_next;
   logic              poll_pending_reg, poll_pending_next;
   logic              m_chipselect_reg, m_chipselect_next;
   logic              m_write_n_reg, m_write_n_next;
   logic [2:0]        m_address_reg, m_address_next;
   logic [31:0]       m_writedata_reg, m_writedata_next;
   logic              rsp_valid_reg, rsp_valid_next;
   logic [31:0]       rsp_rdata_reg, rsp_rdata_next;
   logic              event_valid_reg, event_valid_next;
   logic [31:0]       event_bits_reg, event_bits_next;

   // A pending poll only counts while polling is enabled, so dropping
   // poll_enable releases cmd_ready in the same cycle.
   logic poll_req;
   assign poll_req  = poll_pending_reg && poll_enable;
   assign cmd_ready = (state_reg == ST_IDLE) && !poll_req && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= ST_IDLE;
         wait_cnt_reg     <= '0;
         poll_cnt_reg     <= CNT_RELOAD;
         poll_pending_reg <= 1'b0;
         m_chipselect_reg <= 1'b0;
         m_write_n_reg    <= 1'b1;
         m_address_reg    <= 3'd0;
         m_writedata_reg  <= 32'd0;
         rsp_valid_reg    <= 1'b0;
         rsp_rdata_reg    <= 32'd0;
         event_valid_reg  <= 1'b0;
         event_bits_reg   <= 32'd0;
      end else begin
         state_reg        <= state_next;
         wait_cnt_reg     <= wait_cnt_next;
         poll_cnt_reg     <= poll_cnt_next;
         poll_pending_reg <= poll_pending_next;
         m_chipselect_reg <= m_chipselect_next;
         m_write_n_reg    <= m_write_n_next;
         m_address_reg    <= m_address_next;
         m_writedata_reg  <= m_writedata_next;
         rsp_valid_reg    <= rsp_valid_next;
         rsp_rdata_reg    <= rsp_rdata_next;
         event_valid_reg  <= event_valid_next;
         event_bits_reg   <= event_bits_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      wait_cnt_next     = wait_cnt_reg;
      poll_cnt_next     = poll_cnt_reg;
      poll_pending_next = poll_pending_reg;
      m_chipselect_next = 1'b0;
      m_write_n_next    = 1'b1;
      m_address_next    = m_address_reg;
      m_writedata_next  = m_writedata_reg;
      rsp_valid_next    = 1'b0;
      rsp_rdata_next    = rsp_rdata_reg;
      event_valid_next  = 1'b0;
      event_bits_next   = event_bits_reg;

      case (state_reg)
         ST_IDLE: begin
            if (poll_req) begin
               state_next        = ST_POLL_RD;
               wait_cnt_next     = '0;
               m_chipselect_next = 1'b1;
               m_address_next    = EDGE_ADDR;
               poll_pending_next = 1'b0;
            end else if (cmd_valid) begin
               m_chipselect_next = 1'b1;
               m_address_next    = cmd_address;
               if (cmd_write) begin
                  state_next       = ST_CMD_WR;
                  m_write_n_next   = 1'b0;
                  m_writedata_next = cmd_wdata;
               end else begin
                  state_next    = ST_CMD_RD;
                  wait_cnt_next = '0;
               end
            end
         end
         ST_CMD_WR: begin
            state_next     = ST_CMD_RSP;
            rsp_valid_next = 1'b1;
            rsp_rdata_next = 32'd0;
         end
         ST_CMD_RD: begin
            if (wait_cnt_reg == WAIT_LAST) begin
               state_next     = ST_CMD_RSP;
               rsp_valid_next = 1'b1;
               rsp_rdata_next = m_readdata;
            end else begin
               wait_cnt_next     = wait_cnt_reg + WAIT_W'(1);
               m_chipselect_next = 1'b1;
            end
         end
         ST_CMD_RSP: begin
            state_next = ST_IDLE;
         end
         ST_POLL_RD: begin
            if (wait_cnt_reg == WAIT_LAST) begin
               if (m_readdata != 32'd0) begin
                  // Write the captured bits back to clear exactly those bits.
                  state_next        = ST_POLL_CLR;
                  m_chipselect_next = 1'b1;
                  m_write_n_next    = 1'b0;
                  m_writedata_next  = m_readdata;
                  event_valid_next  = 1'b1;
                  event_bits_next   = m_readdata;
               end else begin
                  state_next = ST_IDLE;
               end
            end else begin
               wait_cnt_next     = wait_cnt_reg + WAIT_W'(1);
               m_chipselect_next = 1'b1;
            end
         end
         ST_POLL_CLR: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Poll timer; evaluated after the FSM so an expiry coinciding with a
      // grant re-arms the request rather than being lost.
      if (!poll_enable) begin
         poll_cnt_next     = CNT_RELOAD;
         poll_pending_next = 1'b0;
      end else if (poll_cnt_reg == '0) begin
         poll_cnt_next     = CNT_RELOAD;
         poll_pending_next = 1'b1;
      end else begin
         poll_cnt_next = poll_cnt_reg - CNT_W'(1);
      end
   end

   assign m_chipselect = m_chipselect_reg;
   assign m_write_n    = m_write_n_reg;
   assign m_address    = m_address_reg;
   assign m_writedata  = m_writedata_reg;
   assign rsp_valid    = rsp_valid_reg;
   assign rsp_rdata    = rsp_rdata_reg;
   assign event_valid  = event_valid_reg;
   assign event_bits   = event_bits_reg;

endmodule

// File: tb/tb_currctrl_gpio_master.sv
// -----------------------------------------------------------------------------
// tb_currctrl_gpio_master
//
// Directed bench for currctrl_gpio_master with a small behavioural model of
// the PIO slave (data out, set/clear bits, falling-edge capture, registered
// readdata). Poll period is shortened to 16 cycles.
// -----------------------------------------------------------------------------
module tb_currctrl_gpio_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [2:0]  cmd_address;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        poll_enable;
   logic        event_valid;
   logic [31:0] event_bits;
   logic [2:0]  m_address;
   logic        m_chipselect;
   logic        m_write_n;
   logic [31:0] m_writedata;
   logic [31:0] m_readdata;

   // PIO slave model state
   logic [31:0] in_port;
   logic [31:0] in_prev;
   logic [31:0] out_port;
   logic [31:0] edge_cap;

   int checks_cnt = 0;
   int fail_cnt   = 0;

   always #5 clk = ~clk;

   currctrl_gpio_master #(
      .POLL_PERIOD(16),
      .READ_WAIT  (1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_address (cmd_address),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .poll_enable (poll_enable),
      .event_valid (event_valid),
      .event_bits  (event_bits),
      .m_address   (m_address),
      .m_chipselect(m_chipselect),
      .m_write_n   (m_write_n),
      .m_writedata (m_writedata),
      .m_readdata  (m_readdata)
   );

   // PIO slave: readdata registered one cycle after address/chipselect.
   always @(posedge clk) begin
      if (reset) begin
         in_prev    <= 32'd0;
         out_port   <= 32'd0;
         edge_cap   <= 32'd0;
         m_readdata <= 32'd0;
      end else begin
         in_prev <= in_port;
         if (m_chipselect && !m_write_n) begin
            case (m_address)
               3'd0: out_port <= m_writedata;
               3'd4: out_port <= out_port | m_writedata;
               3'd5: out_port <= out_port & ~m_writedata;
               default: ;
            endcase
         end
         edge_cap <= (edge_cap & ~((m_chipselect && !m_write_n && m_address == 3'd3)
                                   ? m_writedata : 32'd0))
                     | (in_prev & ~in_port);
         if (m_chipselect) begin
            case (m_address)
               3'd0:    m_readdata <= in_port;
               3'd3:    m_readdata <= edge_cap;
               default: m_readdata <= 32'd0;
            endcase
         end else begin
            m_readdata <= 32'd0;
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Issue one command starting in the current cycle T and check its timing.
   task automatic run_cmd(input logic wr, input logic [2:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rdata, input string tag);
      cmd_valid   = 1'b1;
      cmd_write   = wr;
      cmd_address = addr;
      cmd_wdata   = wd;
      @(negedge clk);
      check_val({tag, "_ready"}, cmd_ready, 1);
      next_cycle();                              // T+1
      cmd_valid = 1'b0;
      @(negedge clk);
      check_val({tag, "_cs1"}, m_chipselect, 1);
      check_val({tag, "_wn1"}, m_write_n, wr ? 32'd0 : 32'd1);
      check_val({tag, "_addr1"}, m_address, addr);
      if (wr) check_val({tag, "_wdata"}, m_writedata, wd);
      check_val({tag, "_rsp_early"}, rsp_valid, 0);
      if (!wr) begin
         next_cycle();                           // T+2
         @(negedge clk);
         check_val({tag, "_cs2"}, m_chipselect, 1);
         check_val({tag, "_addr2"}, m_address, addr);
         check_val({tag, "_rsp_early2"}, rsp_valid, 0);
      end
      next_cycle();                              // response cycle
      @(negedge clk);
      check_val({tag, "_rsp"}, rsp_valid, 1);
      check_val({tag, "_rdata"}, rsp_rdata, exp_rdata);
      check_val({tag, "_cs_off"}, m_chipselect, 0);
      check_val({tag, "_busy"}, cmd_ready, 0);
      next_cycle();
      @(negedge clk);
      check_val({tag, "_rsp_end"}, rsp_valid, 0);
      check_val({tag, "_ready_again"}, cmd_ready, 1);
      $display("txn %s wr=%0d addr=%0d wdata=0x%08h rdata=0x%08h", tag, wr, addr, wd, rsp_rdata);
      next_cycle();
   endtask

   initial begin
      int cs_cycles;
      int wr_cycles;
      int ev_cycles;
      reset       = 1'b1;
      cmd_valid   = 1'b0;
      cmd_write   = 1'b0;
      cmd_address = 3'd0;
      cmd_wdata   = 32'd0;
      poll_enable = 1'b0;
      in_port     = 32'd0;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_cs", m_chipselect, 0);
      check_val("rst_wn", m_write_n, 1);
      check_val("rst_addr", m_address, 0);
      check_val("rst_wdata", m_writedata, 0);
      check_val("rst_rsp", rsp_valid, 0);
      check_val("rst_rdata", rsp_rdata, 0);
      check_val("rst_ev", event_valid, 0);
      check_val("rst_evbits", event_bits, 0);
      check_val("rst_ready", cmd_ready, 0);
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      check_val("post_rst_ready", cmd_ready, 1);
      next_cycle();

      // Register access
      run_cmd(1'b1, 3'd0, 32'hA5A5_0001, 32'd0, "wr_data");
      check_val("out_port_wr", out_port, 32'hA5A5_0001);
      in_port = 32'h1234_5678;
      next_cycle();
      run_cmd(1'b0, 3'd0, 32'd0, 32'h1234_5678, "rd_data");
      run_cmd(1'b1, 3'd4, 32'h0000_00F0, 32'd0, "wr_set");
      check_val("out_port_set", out_port, 32'hA5A5_00F1);
      run_cmd(1'b1, 3'd5, 32'h0000_0001, 32'd0, "wr_clr");
      check_val("out_port_clr", out_port, 32'hA5A5_00F0);
      run_cmd(1'b0, 3'd2, 32'd0, 32'd0, "rd_unmapped");

      // Edge capture via commands (falling edges on bits 6..3)
      in_port = 32'h1234_5600;
      next_cycle();
      next_cycle();
      run_cmd(1'b0, 3'd3, 32'd0, 32'h0000_0078, "rd_edge");
      run_cmd(1'b1, 3'd3, 32'hFFFF_FFFF, 32'd0, "wr_edge_clr");
      run_cmd(1'b0, 3'd3, 32'd0, 32'd0, "rd_edge_zero");

      // Falling edge on bit 7, then start the poller
      in_port = 32'h1234_5680;
      next_cycle();
      in_port = 32'h1234_5600;
      next_cycle();
      next_cycle();
      check_val("edge_cap_b7", edge_cap, 32'h0000_0080);
      poll_enable = 1'b1;
      repeat (16) next_cycle();                  // cycle P: poll_pending high
      @(negedge clk);
      check_val("poll_P_ready", cmd_ready, 0);
      check_val("poll_P_cs", m_chipselect, 0);
      next_cycle();
      @(negedge clk);
      check_val("poll_rd1_cs", m_chipselect, 1);
      check_val("poll_rd1_wn", m_write_n, 1);
      check_val("poll_rd1_addr", m_address, 3);
      next_cycle();
      @(negedge clk);
      check_val("poll_rd2_cs", m_chipselect, 1);
      check_val("poll_rd2_addr", m_address, 3);
      check_val("poll_rd2_ev", event_valid, 0);
      next_cycle();
      @(negedge clk);
      check_val("poll_clr_cs", m_chipselect, 1);
      check_val("poll_clr_wn", m_write_n, 0);
      check_val("poll_clr_addr", m_address, 3);
      check_val("poll_clr_wdata", m_writedata, 32'h0000_0080);
      check_val("poll_ev", event_valid, 1);
      check_val("poll_evbits", event_bits, 32'h0000_0080);
      next_cycle();
      @(negedge clk);
      check_val("poll_idle_cs", m_chipselect, 0);
      check_val("poll_ev_end", event_valid, 0);
      check_val("poll_evbits_hold", event_bits, 32'h0000_0080);
      check_val("poll_idle_ready", cmd_ready, 1);
      check_val("edge_cap_cleared", edge_cap, 0);
      $display("txn poll event_bits=0x%08h", event_bits);

      // Second poll (P+16) reads zero: two read cycles, no write, no event
      cs_cycles = 0;
      wr_cycles = 0;
      ev_cycles = 0;
      for (int c = 5; c <= 20; c++) begin
         next_cycle();
         @(negedge clk);
         if (m_chipselect) cs_cycles++;
         if (m_chipselect && !m_write_n) wr_cycles++;
         if (event_valid) ev_cycles++;
      end
      check_val("poll0_reads", cs_cycles, 2);
      check_val("poll0_writes", wr_cycles, 0);
      check_val("poll0_events", ev_cycles, 0);
      $display("txn poll zero-sample read_cycles=%0d", cs_cycles);

      // Collision at P+32: command waits behind the poll
      repeat (12) next_cycle();
      cmd_valid   = 1'b1;
      cmd_write   = 1'b1;
      cmd_address = 3'd0;
      cmd_wdata   = 32'h0000_5555;
      @(negedge clk);
      check_val("col_ready_low", cmd_ready, 0);
      next_cycle();
      @(negedge clk);
      check_val("col_poll_cs", m_chipselect, 1);
      check_val("col_poll_addr", m_address, 3);
      check_val("col_poll_wn", m_write_n, 1);
      check_val("col_ready_busy", cmd_ready, 0);
      next_cycle();
      next_cycle();                              // P+35: poll back in IDLE
      @(negedge clk);
      check_val("col_accept", cmd_ready, 1);
      check_val("col_gap_cs", m_chipselect, 0);
      next_cycle();
      cmd_valid = 1'b0;
      @(negedge clk);
      check_val("col_wr_cs", m_chipselect, 1);
      check_val("col_wr_wn", m_write_n, 0);
      check_val("col_wr_addr", m_address, 0);
      check_val("col_wr_wdata", m_writedata, 32'h0000_5555);
      next_cycle();
      @(negedge clk);
      check_val("col_rsp", rsp_valid, 1);
      check_val("col_out_port", out_port, 32'h0000_5555);
      $display("txn collision write wdata=0x%08h", 32'h0000_5555);

      // Disable at P+48, the cycle poll_pending rises
      repeat (11) next_cycle();
      poll_enable = 1'b0;
      @(negedge clk);
      check_val("dis_ready", cmd_ready, 1);
      next_cycle();
      @(negedge clk);
      check_val("dis_no_poll1", m_chipselect, 0);
      next_cycle();
      @(negedge clk);
      check_val("dis_no_poll2", m_chipselect, 0);
      $display("txn poll disabled while pending");
      next_cycle();

      // Reset during CMD_RD cycle 1
      cmd_valid   = 1'b1;
      cmd_write   = 1'b0;
      cmd_address = 3'd0;
      @(negedge clk);
      check_val("rr_accept", cmd_ready, 1);
      next_cycle();
      cmd_valid = 1'b0;
      reset     = 1'b1;
      @(negedge clk);
      check_val("rr_rd_cs", m_chipselect, 1);
      check_val("rr_ready_in_reset", cmd_ready, 0);
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      check_val("rr_cs_released", m_chipselect, 0);
      check_val("rr_no_rsp1", rsp_valid, 0);
      check_val("rr_ready", cmd_ready, 1);
      next_cycle();
      @(negedge clk);
      check_val("rr_no_rsp2", rsp_valid, 0);
      $display("txn read aborted by reset");
      next_cycle();
      run_cmd(1'b0, 3'd0, 32'd0, 32'h1234_5600, "rd_after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
